if_fetch_unit: RTL and testbench

//  Instruction-fetch front end that produces the if_pc/if_inst pair consumed by the IF/ID pipeline register.

---
 rtl/if_fetch_unit.sv | 143 ++++++++++++++
 tb/tb_if_fetch_unit.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: PC generation, credit-limited ROM requests, and an
// in-order instruction buffer that drops responses to fetches made stale by a redirect.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        rom_req_valid,
  input  logic        rom_req_ready,
  output logic [31:0] rom_addr,
  input  logic        rom_rsp_valid,
  input  logic [31:0] rom_rsp_inst,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
  localparam logic [31:0]   ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic {S_IDLE, S_FETCH} state_e;

  state_e          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
  logic [CW-1:0]   buf_count_q, buf_count_d;
  logic [PW-1:0]   af_rd_q, af_rd_d, af_wr_q, af_wr_d;
  logic [PW-1:0]   buf_rd_q, buf_rd_d, buf_wr_q, buf_wr_d;
  logic [31:0]     af_mem_q   [DEPTH];
  logic [31:0]     buf_pc_q   [DEPTH];
  logic [31:0]     buf_inst_q [DEPTH];

  logic req_fire, rsp_take, rsp_keep, pop, af_push;

  // ---------------- FSM: state register / next state / outputs ----------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: state_d = S_FETCH;
      default: state_d = S_IDLE;
    endcase
  end

  // A request is only raised while a slot is guaranteed for its response.
  always_comb begin
    rom_req_valid = 1'b0;
    if (state_q == S_FETCH) rom_req_valid = (outstanding_q + buf_count_q) < DEPTH_C;
  end

  assign rom_addr = pc_q;
  assign if_valid = (buf_count_q != '0);
  assign if_pc    = buf_pc_q[buf_rd_q];
  assign if_inst  = buf_inst_q[buf_rd_q];

  // ---------------- datapath ----------------
  assign req_fire = rom_req_valid && rom_req_ready;
  assign rsp_take = rom_rsp_valid && (outstanding_q != '0);
  assign rsp_keep = rsp_take && (drop_cnt_q == '0) && !branch_flag_i;
  assign pop      = if_valid && if_ready && !branch_flag_i;
  assign af_push  = req_fire && !branch_flag_i;

  // NOTE: every signal gets a default at the top of always_comb, so no latch is inferred.
  always_comb begin
    pc_d          = pc_q;
    outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_take);
    drop_cnt_d    = drop_cnt_q;
    af_wr_d       = af_wr_q + PW'(af_push);
    af_rd_d       = af_rd_q + PW'(rsp_keep);
    buf_wr_d      = buf_wr_q + PW'(rsp_keep);
    buf_rd_d      = buf_rd_q + PW'(pop);
    buf_count_d   = buf_count_q + CW'(rsp_keep) - CW'(pop);

    if (req_fire) pc_d = (pc_q + PC_STEP) & ALIGN_MASK;
    if (rsp_take && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - 1'b1;

    // Redirect wins: everything still in flight after this edge is stale.
    if (branch_flag_i) begin
      pc_d        = branch_target_i & ALIGN_MASK;
      drop_cnt_d  = outstanding_d;
      af_wr_d     = '0;
      af_rd_d     = '0;
      buf_wr_d    = '0;
      buf_rd_d    = '0;
      buf_count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC & ALIGN_MASK;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      buf_count_q   <= '0;
      af_rd_q       <= '0;
      af_wr_q       <= '0;
      buf_rd_q      <= '0;
      buf_wr_q      <= '0;
    end else begin
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      buf_count_q   <= buf_count_d;
      af_rd_q       <= af_rd_d;
      af_wr_q       <= af_wr_d;
      buf_rd_q      <= buf_rd_d;
      buf_wr_q      <= buf_wr_d;
    end
  end

  // NOTE: the address FIFO needs no reset (pointers guard it); the buffer is reset
  // because its head drives if_pc/if_inst directly and those must read 0 after reset.
  always_ff @(posedge clk) begin
    if (af_push) af_mem_q[af_wr_q] <= pc_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        buf_pc_q[i]   <= '0;
        buf_inst_q[i] <= '0;
      end
    end else if (rsp_keep) begin
      buf_pc_q[buf_wr_q]   <= af_mem_q[af_rd_q];
      buf_inst_q[buf_wr_q] <= rom_rsp_inst;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: a ROM model with random in-order latency drives the
// DUT; the expected stream is the sequential PC walk restarted at every redirect/reset.
module tb_if_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'hFFFF_FFF8;
  localparam logic [31:0] ALIGN    = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rom_req_valid;
  logic        rom_req_ready = 1'b0;
  logic [31:0] rom_addr;
  logic        rom_rsp_valid = 1'b0;
  logic [31:0] rom_rsp_inst = '0;
  logic        branch_flag_i = 1'b0;
  logic [31:0] branch_target_i = '0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_pc;
  logic [31:0] if_inst;

  if_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(4), .PC_STEP(32'd4)) dut (
    .clk(clk), .rst(rst),
    .rom_req_valid(rom_req_valid), .rom_req_ready(rom_req_ready), .rom_addr(rom_addr),
    .rom_rsp_valid(rom_rsp_valid), .rom_rsp_inst(rom_rsp_inst),
    .branch_flag_i(branch_flag_i), .branch_target_i(branch_target_i),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_inst(if_inst)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; } rom_req_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; } exp_t;

  rom_req_t    rom_q[$];
  exp_t        sb_q[$];
  logic [31:0] gen_pc;
  int compared = 0, mismatched = 0, delivered = 0, cyc = 0, last_due = 0;
  int unsigned ready_pct = 100, ifr_pct = 100, br_pct = 0, lat_min = 1, lat_max = 1;
  bit          force_br = 0;
  logic [31:0] force_tgt = '0;
  int          br_when_pending = 0;
  logic [31:0] pend_tgt = '0;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected stream: sequential PCs from the last reset/redirect base.
  task automatic sb_topup();
    exp_t e;
    while (sb_q.size() < 8) begin
      e.pc = gen_pc; e.inst = rom_word(gen_pc);
      sb_q.push_back(e);
      gen_pc = gen_pc + 32'd4;
    end
  endtask

  task automatic sb_restart(input logic [31:0] base);
    sb_q.delete();
    gen_pc = base;
    sb_topup();
  endtask

  // One clock of stimulus: drive after the rising edge, record ROM acceptance at the falling edge.
  task automatic cycle();
    rom_req_t r;
    int lat;
    @(posedge clk); #1;
    rom_rsp_valid = 1'b0;
    rom_rsp_inst  = '0;
    if (rom_q.size() != 0 && rom_q[0].due <= cyc) begin
      rom_rsp_valid = 1'b1;
      rom_rsp_inst  = rom_word(rom_q[0].addr);
      void'(rom_q.pop_front());
    end
    rom_req_ready = ($urandom_range(99) < ready_pct);
    if_ready      = ($urandom_range(99) < ifr_pct);
    branch_flag_i = 1'b0;
    if (force_br) begin
      branch_flag_i = 1'b1; branch_target_i = force_tgt; force_br = 0;
    end else if (br_when_pending > 0 && rom_q.size() >= br_when_pending) begin
      branch_flag_i = 1'b1; branch_target_i = pend_tgt; br_when_pending = 0;
    end else if ($urandom_range(99) < br_pct) begin
      branch_flag_i = 1'b1; branch_target_i = $urandom();
    end
    if (branch_flag_i) sb_restart(branch_target_i & ALIGN);
    @(negedge clk);
    if (rom_req_valid && rom_req_ready) begin
      check("rom_addr_align", {30'd0, rom_addr[1:0]}, 32'd0);
      lat = int'($urandom_range(lat_max, lat_min));
      r.addr = rom_addr;
      r.due  = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
      last_due = r.due;
      rom_q.push_back(r);
    end
    cyc++;
  endtask

  task automatic reset_seq();
    @(posedge clk); #1;
    rst = 1'b1; rom_req_ready = 1'b0; rom_rsp_valid = 1'b0; rom_rsp_inst = '0;
    if_ready = 1'b0; branch_flag_i = 1'b0; branch_target_i = '0;
    rom_q.delete(); last_due = 0;
    sb_restart(RESET_PC);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_valid", {31'd0, rom_req_valid}, 32'd0);
    check("rst_if_valid",  {31'd0, if_valid}, 32'd0);
    check("rst_if_pc",     if_pc, 32'd0);
    check("rst_if_inst",   if_inst, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("idle_no_req", {31'd0, rom_req_valid}, 32'd0);
    cyc++;
    @(posedge clk); #1;
    @(negedge clk);
    check("first_req_valid", {31'd0, rom_req_valid}, 32'd1);
    check("first_req_addr",  rom_addr, RESET_PC);
    cyc++;
  endtask

  // Monitor: compares every accepted instruction and the hold-stable rule under stall.
  bit          prev_hold = 0;
  logic [31:0] prev_pc, prev_inst;
  always @(negedge clk) begin
    exp_t e;
    if (prev_hold) begin
      check("stall_valid", {31'd0, if_valid}, 32'd1);
      check("stall_pc",    if_pc,   prev_pc);
      check("stall_inst",  if_inst, prev_inst);
    end
    prev_hold = !rst && if_valid && !if_ready && !branch_flag_i;
    prev_pc   = if_pc;
    prev_inst = if_inst;
    if (!rst && if_valid && if_ready && !branch_flag_i) begin
      if (sb_q.size() == 0) begin
        mismatched++;
        $display("FAIL sb_empty: unexpected instruction pc %h", if_pc);
      end else begin
        e = sb_q.pop_front();
        check("if_pc",   if_pc,   e.pc);
        check("if_inst", if_inst, e.inst);
        sb_topup();
      end
      delivered++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d0;
    reset_seq();

    // Zero-wait ROM, no stall: full rate, PC wraps past FFFF_FFFC.
    lat_min = 1; lat_max = 1; ready_pct = 100; ifr_pct = 100; br_pct = 0;
    repeat (9) cycle();
    #1 d0 = delivered;
    repeat (20) cycle();
    #1 check("full_rate", 32'(delivered - d0), 32'd20);

    // Redirect in a cycle with a handshake and a response in flight.
    force_br = 1; force_tgt = 32'h0000_0200;
    repeat (11) cycle();

    // Five-cycle stall: request channel must close once all credits are used.
    ifr_pct = 0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      if (i >= 3) check("stall_no_req", {31'd0, rom_req_valid}, 32'd0);
    end
    ifr_pct = 100;
    repeat (10) cycle();

    // Redirect to unaligned 0x103 with fetches outstanding: next PC must be 0x100.
    lat_min = 3; lat_max = 3;
    br_when_pending = 2; pend_tgt = 32'h0000_0103;
    for (int i = 0; i < 20 && br_when_pending != 0; i++) cycle();
    check("branch_103_issued", 32'(br_when_pending), 32'd0);
    repeat (15) cycle();

    // Random latency, back-pressure and redirects.
    #1 d0 = delivered;
    lat_min = 1; lat_max = 5; ready_pct = 60; ifr_pct = 70; br_pct = 3;
    repeat (3000) cycle();
    #1 check("random_progress", {31'd0, (delivered - d0) >= 300}, 32'd1);

    // Reset mid-operation, then resume.
    reset_seq();
    lat_min = 1; lat_max = 2; ready_pct = 80; ifr_pct = 80; br_pct = 0;
    #1 d0 = delivered;
    repeat (40) cycle();
    #1 check("post_reset_progress", {31'd0, (delivered - d0) >= 10}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
